// File: rtl/finalsoc_spi_pkg.sv
// Shared definitions for the SPI register responder: FSM states,
// command byte field positions and register-file depth.
package finalsoc_spi_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMD  = 2'd1,
    DATA = 2'd2
  } spi_state_t;

  // Command byte layout: addr = cmd[7:3], write flag = cmd[1]
  localparam int ADDR_MSB  = 7;
  localparam int ADDR_LSB  = 3;
  localparam int WRITE_BIT = 1;

  // Register file depth (5-bit address space)
  localparam int NREGS = 32;

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchronizer for one asynchronous SPI input, plus
// single-cycle rise/fall strobes of the synchronized level.
module spi_sync_edge #(
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic dout,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync_q;
  logic              prev_q;

  // Shift the raw input through the synchronizer chain and keep the
  // previous synchronized level for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= {STAGES{RESET_VAL}};
      prev_q <= RESET_VAL;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], din};
      prev_q <= sync_q[STAGES-1];
    end
  end

  assign dout = sync_q[STAGES-1];
  assign rise = dout & ~prev_q;
  assign fall = ~dout & prev_q;

endmodule

// File: rtl/spi_reg_responder.sv
// SPI mode-0 slave fronting a 32 x 8 register file. The first byte of a
// transaction is a command (address + write flag); following bytes are
// written to or read from consecutive addresses. All SPI inputs are
// oversampled by the 50 MHz system clock.
module spi_reg_responder #(
  parameter int SYNC_STAGES = 2,
  parameter int NREGS       = 32
) (
  input  logic       clk_50_clk,
  input  logic       reset_50_reset_n,
  input  logic       spi_SCLK,
  input  logic       spi_SS_n,
  input  logic       spi_MOSI,
  output logic       spi_MISO,
  output logic       spi_MISO_oe,
  input  logic [7:0] status_in,
  input  logic [4:0] rd_addr,
  output logic [7:0] rd_data,
  output logic       wr_valid,
  output logic [4:0] wr_addr,
  output logic [7:0] wr_data
);

  import finalsoc_spi_pkg::*;

  localparam logic [1:0] SETTLE_MAX = 2'(SYNC_STAGES);

  logic sclk_s, sclk_rise, sclk_fall;
  logic ss_s, ss_fall, ss_rise_unused;
  logic mosi_s, mosi_rise_unused, mosi_fall_unused;

  spi_state_t state_q, state_d;
  logic [2:0] bit_cnt_q;
  logic [7:0] rx_shift_q;
  logic [7:0] tx_shift_q;
  logic [4:0] addr_q;
  logic       is_write_q;
  logic       byte_done_q;
  logic [7:0] regs_q [NREGS];
  logic [1:0] settle_q;
  logic       armed_q;

  logic [7:0] rx_byte;
  logic       byte_end;
  logic       enter_cmd;

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sclk (
    .clk(clk_50_clk), .rst_n(reset_50_reset_n), .din(spi_SCLK),
    .dout(sclk_s), .rise(sclk_rise), .fall(sclk_fall)
  );

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_ss (
    .clk(clk_50_clk), .rst_n(reset_50_reset_n), .din(spi_SS_n),
    .dout(ss_s), .rise(ss_rise_unused), .fall(ss_fall)
  );

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_mosi (
    .clk(clk_50_clk), .rst_n(reset_50_reset_n), .din(spi_MOSI),
    .dout(mosi_s), .rise(mosi_rise_unused), .fall(mosi_fall_unused)
  );

  assign rx_byte   = {rx_shift_q[6:0], mosi_s};
  assign byte_end  = sclk_rise && (bit_cnt_q == 3'd7);
  assign enter_cmd = (state_q == IDLE) && (state_d == CMD);

  // After reset, wait for the synchronizers to flush and then for SS_n to
  // be seen high, so a transaction cut by reset is never picked up midway.
  always_ff @(posedge clk_50_clk or negedge reset_50_reset_n) begin
    if (!reset_50_reset_n) begin
      settle_q <= 2'd0;
      armed_q  <= 1'b0;
    end else begin
      if (settle_q != SETTLE_MAX) settle_q <= settle_q + 2'd1;
      armed_q <= armed_q | ((settle_q == SETTLE_MAX) && ss_s);
    end
  end

  // FSM state register.
  always_ff @(posedge clk_50_clk or negedge reset_50_reset_n) begin
    if (!reset_50_reset_n) state_q <= IDLE;
    else                   state_q <= state_d;
  end

  // Next-state logic: select opens a transaction, the 8th rise ends the
  // command byte, deselect always returns to IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (armed_q && (ss_fall || !ss_s)) state_d = CMD;
      CMD:     if (ss_s) state_d = IDLE;
               else if (byte_end) state_d = DATA;
      DATA:    if (ss_s) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Shift registers, bit counter, address pointer and register file.
  always_ff @(posedge clk_50_clk or negedge reset_50_reset_n) begin
    if (!reset_50_reset_n) begin
      bit_cnt_q   <= 3'd0;
      rx_shift_q  <= 8'h00;
      tx_shift_q  <= 8'h00;
      addr_q      <= 5'd0;
      is_write_q  <= 1'b0;
      byte_done_q <= 1'b0;
      wr_valid    <= 1'b0;
      wr_addr     <= 5'd0;
      wr_data     <= 8'h00;
      for (int i = 0; i < NREGS; i++) regs_q[i] <= 8'h00;
    end else begin
      wr_valid <= 1'b0;
      if (state_d == IDLE) begin
        bit_cnt_q   <= 3'd0;
        rx_shift_q  <= 8'h00;
        tx_shift_q  <= 8'h00;
        byte_done_q <= 1'b0;
      end else if (enter_cmd) begin
        bit_cnt_q   <= 3'd0;
        rx_shift_q  <= 8'h00;
        tx_shift_q  <= status_in;
        byte_done_q <= 1'b0;
      end else if (sclk_rise) begin
        rx_shift_q <= rx_byte;
        bit_cnt_q  <= bit_cnt_q + 3'd1;
        if (byte_end) begin
          byte_done_q <= 1'b1;
          if (state_q == CMD) begin
            addr_q     <= rx_byte[ADDR_MSB:ADDR_LSB];
            is_write_q <= rx_byte[WRITE_BIT];
          end else begin
            addr_q <= addr_q + 5'd1;
            if (is_write_q) begin
              regs_q[addr_q] <= rx_byte;
              wr_valid       <= 1'b1;
              wr_addr        <= addr_q;
              wr_data        <= rx_byte;
            end
          end
        end
      end else if (sclk_fall) begin
        if (byte_done_q) begin
          byte_done_q <= 1'b0;
          tx_shift_q  <= is_write_q ? 8'h00 : regs_q[addr_q];
        end else begin
          tx_shift_q <= {tx_shift_q[6:0], 1'b0};
        end
      end
    end
  end

  assign spi_MISO_oe = (state_q != IDLE);
  assign spi_MISO    = spi_MISO_oe & tx_shift_q[7];
  assign rd_data     = regs_q[rd_addr];

endmodule

// File: doc/spi_reg_responder.md
SPI_REG_RESPONDER -- requirements
Module: spi_reg_responder

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, meaning flip-flop depth of the SCLK/SS_n/MOSI synchronizers (legal 2..3).
REQ-002 SHALL have parameter NREGS, default 32, meaning register-file depth; fixed at 32 (5-bit address).
REQ-003 SHALL have port clk_50_clk, input, 1, meaning the single system clock (50 MHz); all logic on its rising edge.
REQ-004 SHALL have port reset_50_reset_n, input, 1, meaning the reset: asynchronous, active-low.
REQ-005 SHALL have port spi_SCLK, input, 1, meaning the SPI clock from the master (mode 0, CPOL=0 CPHA=0).
REQ-006 SHALL have port spi_SS_n, input, 1, meaning the active-low slave select; low frames one transaction.
REQ-007 SHALL have port spi_MOSI, input, 1, meaning master-to-slave data, MSB first.
REQ-008 SHALL have port spi_MISO, output, 1, meaning slave-to-master data, MSB first.
REQ-009 SHALL have port spi_MISO_oe, output, 1, meaning MISO drive enable; high only while selected.
REQ-010 SHALL have port status_in, input, 8, meaning the status byte returned during the command byte.
REQ-011 SHALL have port rd_addr, input, 5, meaning the local read address.
REQ-012 SHALL have port rd_data, output, 8, meaning the combinational contents of reg[rd_addr].
REQ-013 SHALL have port wr_valid, output, 1, meaning a one-cycle pulse per completed SPI write byte.
REQ-014 SHALL have port wr_addr, output, 5, meaning the register written; valid with wr_valid.
REQ-015 SHALL have port wr_data, output, 8, meaning the byte written; valid with wr_valid.

Function
REQ-016 SHALL synchronize SCLK, SS_n and MOSI through SYNC_STAGES flops and derive single-cycle rise/fall strobes of SCLK and a fall strobe of SS_n.
REQ-017 SHALL support an SCLK high or low phase of at least 4 clk_50_clk cycles (SCLK <= 6.25 MHz); faster SCLK is undefined.
REQ-018 SHALL implement FSM states IDLE, CMD, DATA: IDLE->CMD on synchronized SS_n low; CMD->DATA after the 8th SCLK rise; DATA->DATA per byte; any state->IDLE on synchronized SS_n high.
REQ-019 SHALL sample MOSI on the SCLK rise strobe and shift out MISO on the SCLK fall strobe.
REQ-020 SHALL decode the command byte as addr=cmd[7:3], write=cmd[1]; cmd[2] and cmd[0] ignored.
REQ-021 SHALL load status_in into the MISO shifter on entry to CMD, driving bit 7 before the first SCLK rise.
REQ-022 SHALL, for a read command, load reg[addr] into the MISO shifter on the SCLK fall following the 8th rise of each byte, so its MSB is valid before the next byte's first rise.
REQ-023 SHALL, for a write command, on each 8th data-byte rise write the byte to reg[addr] and pulse wr_valid with wr_addr/wr_data in the same cycle, 1 cycle after the rise strobe.
REQ-024 SHALL increment addr after every data byte (read or write), wrapping 31->0.
REQ-025 SHALL, in a write transaction, drive MISO 0 during data bytes.
REQ-026 SHALL discard a partial byte (fewer than 8 rises) when SS_n deasserts; no register write, no wr_valid.
REQ-027 SHALL treat SS_n falling again without an intervening clean IDLE as a new transaction, restarting at CMD with bit count 0.
REQ-028 SHALL drive spi_MISO_oe = 1 in CMD and DATA, 0 in IDLE; spi_MISO = 0 whenever spi_MISO_oe = 0.

Reset
REQ-029 SHALL, while reset_50_reset_n is low, force state IDLE, bit counter 0, shifters 0, all 32 registers 0x00, synchronizer flops to idle levels (SCLK 0, SS_n 1, MOSI 0), spi_MISO 0, spi_MISO_oe 0, wr_valid 0, wr_addr 0, wr_data 0.
REQ-030 SHALL, on reset during a transaction, abandon it; the block resumes only at the next SS_n falling edge after release.

Structure
REQ-031 SHALL place the FSM state enum, command bit positions (ADDR_MSB=7, ADDR_LSB=3, WRITE_BIT=1) and NREGS in shared package finalsoc_spi_pkg.
REQ-032 SHALL instantiate one sub-module, spi_sync_edge (parameterized synchronizer plus rise/fall strobe generator), once per SPI input.

Verification
REQ-033 SHALL cover: write cmd 0x0A (addr1), data 0x5A -> reg[1]=0x5A, one wr_valid with wr_addr=1, wr_data=0x5A; MISO during cmd = status_in (0xC3).
REQ-034 SHALL cover: after REQ-033, read cmd 0x08, one data byte -> MISO returns 0x5A, no wr_valid.
REQ-035 SHALL cover: write cmd 0xFA (addr31), data 0x11,0x22 -> reg[31]=0x11, reg[0]=0x22 (wrap), two wr_valid pulses.
REQ-036 SHALL cover: write cmd 0x12, 5 data bits then SS_n high -> reg[2] unchanged, no wr_valid, MISO_oe falls within SYNC_STAGES+1 cycles.
REQ-037 SHALL cover: reset asserted mid data byte -> all outputs at reset values next cycle; after release a full write to addr3 of 0x77 succeeds.
REQ-038 SHALL cover: SCLK half-period exactly 4 clk cycles, 4-byte read burst from addr 4 -> bytes equal reg[4..7] with no bit errors.
